// File: rtl/uart_pkg.sv
// Shared constants and types for the serial-port feeder: SFR addresses,
// SCON bit positions and the feeder FSM state encoding.
package uart_pkg;

    // SFR addresses of the serial port
    localparam logic [7:0] SCON_ADDR_DEF = 8'h98;
    localparam logic [7:0] SBUF_ADDR_DEF = 8'h99;

    // SCON bit indices
    localparam int SCON_RI    = 0;
    localparam int SCON_TI    = 1;
    localparam int SCON_REN   = 4;
    localparam int SCON_SM_LO = 6;
    localparam int SCON_SM_HI = 7;

    // Feeder FSM states
    typedef enum logic [3:0] {
        ST_INIT_REQ = 4'd0,
        ST_INIT_WR  = 4'd1,
        ST_IDLE     = 4'd2,
        ST_TX_REQ   = 4'd3,
        ST_TX_WR    = 4'd4,
        ST_WAIT_INT = 4'd5,
        ST_POLL_REQ = 4'd6,
        ST_POLL_RD  = 4'd7,
        ST_CLR_WR   = 4'd8
    } feeder_state_t;

    // SCON value with TI cleared and every other bit preserved, so the
    // write-back never disturbs RI or the mode bits the CPU owns.
    function automatic logic [7:0] clear_ti(input logic [7:0] scon_val);
        logic [7:0] r;
        r = scon_val;
        r[SCON_TI] = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO between the producer stream and the bus-master FSM.
// Pushes while full and pops while empty are ignored; pointers wrap
// naturally because DEPTH is a power of two.
module uart_byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign level   = count;
    assign dout    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage array; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; simultaneous push and pop keeps count steady
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Bus-master feeder for the serial port. Buffers producer bytes, then for
// each byte: requests the SFR bus, writes SBUF, waits for the interrupt,
// polls SCON and clears TI with a read-modify-write. SCON is initialised
// once after every reset.
//
// Handshakes: the producer stream transfers a byte on any rising edge where
// s_valid && s_ready; s_ready depends only on FIFO occupancy, never on
// s_valid. On the SFR side bus_req is held until bus_gnt is sampled high,
// after which each access occupies exactly one cycle with strobes driven
// from registers; bus_gnt must remain high through the access cycle(s).
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int         DEPTH     = 8,
    parameter logic [7:0] SCON_ADDR = SCON_ADDR_DEF,
    parameter logic [7:0] SBUF_ADDR = SBUF_ADDR_DEF,
    parameter logic [7:0] SCON_INIT = 8'h40,
    parameter int         POLL_GAP  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic                   bus_req,
    input  logic                   bus_gnt,
    output logic [7:0]             AB_o,
    output logic [7:0]             DB_o,
    output logic                   DB_oe,
    input  logic [7:0]             DB_i,
    output logic                   rd_n,
    output logic                   wr_n,
    input  logic                   Intuart,
    output logic [$clog2(DEPTH):0] level,
    output logic                   busy,
    output logic [3:0]             dbg_state
);

    localparam int GW = $clog2(POLL_GAP + 1);

    feeder_state_t state;
    logic [GW-1:0] gap_cnt;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;

    // The head byte is latched into DB_o on entry to TX_WR, so popping
    // during TX_WR itself is safe.
    assign fifo_pop  = (state == ST_TX_WR);
    assign s_ready   = !fifo_full;
    assign busy      = (state != ST_IDLE) || !fifo_empty;
    assign dbg_state = state;

    uart_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (s_valid),
        .din   (s_data),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    // Bus-master FSM with registered bus outputs and the SCON poll gap counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_INIT_REQ;
            bus_req <= 1'b0;
            AB_o    <= 8'h00;
            DB_o    <= 8'h00;
            DB_oe   <= 1'b0;
            rd_n    <= 1'b1;
            wr_n    <= 1'b1;
            gap_cnt <= '0;
        end else begin
            // Strobes and request drop unless the next state is a REQ or access state
            bus_req <= 1'b0;
            DB_oe   <= 1'b0;
            rd_n    <= 1'b1;
            wr_n    <= 1'b1;
            case (state)
                ST_INIT_REQ: begin
                    bus_req <= 1'b1;
                    if (bus_gnt) begin
                        state <= ST_INIT_WR;
                        AB_o  <= SCON_ADDR;
                        DB_o  <= SCON_INIT;
                        DB_oe <= 1'b1;
                        wr_n  <= 1'b0;
                    end
                end
                ST_INIT_WR: begin
                    state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state   <= ST_TX_REQ;
                        bus_req <= 1'b1;
                    end
                end
                ST_TX_REQ: begin
                    bus_req <= 1'b1;
                    if (bus_gnt) begin
                        state <= ST_TX_WR;
                        AB_o  <= SBUF_ADDR;
                        DB_o  <= fifo_dout;
                        DB_oe <= 1'b1;
                        wr_n  <= 1'b0;
                    end
                end
                ST_TX_WR: begin
                    state   <= ST_WAIT_INT;
                    gap_cnt <= GW'(POLL_GAP);
                end
                ST_WAIT_INT: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end else if (Intuart) begin
                        state   <= ST_POLL_REQ;
                        bus_req <= 1'b1;
                    end
                end
                ST_POLL_REQ: begin
                    bus_req <= 1'b1;
                    if (bus_gnt) begin
                        state <= ST_POLL_RD;
                        AB_o  <= SCON_ADDR;
                        rd_n  <= 1'b0;
                    end
                end
                ST_POLL_RD: begin
                    // Keep the bus straight into the write-back to minimise the RMW window
                    if (DB_i[SCON_TI]) begin
                        state   <= ST_CLR_WR;
                        bus_req <= 1'b1;
                        AB_o    <= SCON_ADDR;
                        DB_o    <= clear_ti(DB_i);
                        DB_oe   <= 1'b1;
                        wr_n    <= 1'b0;
                    end else begin
                        // RI-only interrupt belongs to the CPU; back off and poll again
                        state   <= ST_WAIT_INT;
                        gap_cnt <= GW'(POLL_GAP);
                    end
                end
                ST_CLR_WR: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_INIT_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: a serial-port model answers the bus,
// a scoreboard queue holds expected bus accesses and a negedge monitor
// compares each access the DUT performs.
module tb_uart_tx_feeder;
    import uart_pkg::*;

    localparam int DEPTH    = 8;
    localparam int POLL_GAP = 16;
    localparam logic [7:0] SCON = 8'h98;
    localparam logic [7:0] SBUF = 8'h99;

    logic       clk;
    logic       rst_n;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic       bus_req;
    logic       bus_gnt;
    logic [7:0] AB_o;
    logic [7:0] DB_o;
    logic       DB_oe;
    logic [7:0] DB_i;
    logic       rd_n;
    logic       wr_n;
    logic       Intuart;
    logic [3:0] level;
    logic       busy;
    logic [3:0] dbg_state;

    // Bench state
    logic [16:0] exp_q[$];
    int          rd_cycles[$];
    int          n_checks;
    int          n_fail;
    int          cyc;
    logic [7:0]  scon;
    logic        ri_mode;

    uart_tx_feeder #(
        .DEPTH     (DEPTH),
        .SCON_ADDR (SCON),
        .SBUF_ADDR (SBUF),
        .SCON_INIT (8'h40),
        .POLL_GAP  (POLL_GAP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .bus_req   (bus_req),
        .bus_gnt   (bus_gnt),
        .AB_o      (AB_o),
        .DB_o      (DB_o),
        .DB_oe     (DB_oe),
        .DB_i      (DB_i),
        .rd_n      (rd_n),
        .wr_n      (wr_n),
        .Intuart   (Intuart),
        .level     (level),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    assign DB_i    = scon;
    assign Intuart = scon[SCON_TI] | scon[SCON_RI];

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [16:0] wr_t(input logic [7:0] a, input logic [7:0] d);
        return {1'b1, a, d};
    endfunction

    function automatic logic [16:0] rd_t(input logic [7:0] a);
        return {1'b0, a, 8'h00};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d bus accesses outstanding after %0d cycles, required 0",
                     name, exp_q.size(), n);
            exp_q.delete();
        end
    endtask

    // Driver: offer one byte for one cycle, report whether it was taken
    task automatic push_byte(input logic [7:0] b, output logic acc);
        s_data  = b;
        s_valid = 1'b1;
        acc     = s_ready;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    // Serial-port model: SCON register, TI raised 50 cycles after an SBUF write
    initial begin
        int   ti_timer;
        logic pend;
        scon     = 8'h00;
        ti_timer = 0;
        pend     = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ti_timer = 0;
                pend     = 1'b0;
            end
            if (pend) begin
                scon = 8'h43;
                pend = 1'b0;
            end
            if (ti_timer != 0) begin
                ti_timer--;
                if (ti_timer == 0) scon[SCON_TI] = 1'b1;
            end
            if (!wr_n && AB_o == SBUF) begin
                if (ri_mode) scon = 8'h41;
                else         ti_timer = 50;
            end
            if (!wr_n && AB_o == SCON) scon = DB_o;
            if (!rd_n && ri_mode && scon == 8'h41) pend = 1'b1;
        end
    end

    // Monitor: compare every bus access against the scoreboard queue
    initial begin
        logic [16:0] act;
        logic [16:0] exp;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!wr_n || !rd_n) begin
                act = {!wr_n, AB_o, (!wr_n ? DB_o : 8'h00)};
                if (!rd_n) rd_cycles.push_back(cyc);
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL bus_txn: unexpected access wr=%0d addr=%h data=%h, required none",
                             act[16], act[15:8], act[7:0]);
                end else begin
                    exp = exp_q.pop_front();
                    if (act !== exp) begin
                        n_fail++;
                        $display("FAIL bus_txn: got wr=%0d addr=%h data=%h, required wr=%0d addr=%h data=%h",
                                 act[16], act[15:8], act[7:0], exp[16], exp[15:8], exp[7:0]);
                    end
                end
                n_checks++;
                if (!bus_req || (DB_oe !== !wr_n) || (!wr_n && !rd_n)) begin
                    n_fail++;
                    $display("FAIL strobe_protocol: got bus_req=%0d DB_oe=%0d rd_n=%0d wr_n=%0d, required bus_req=1 DB_oe=~wr_n single strobe",
                             bus_req, DB_oe, rd_n, wr_n);
                end
            end
        end
    end

    // Stimulus
    initial begin
        logic acc;
        int   n_acc;
        int   base;
        int   gap;
        n_checks = 0;
        n_fail   = 0;
        ri_mode  = 1'b0;
        rst_n    = 1'b1;
        bus_gnt  = 1'b1;
        s_valid  = 1'b0;
        s_data   = 8'h00;

        // Reset values
        #1 rst_n = 1'b0;
        #1;
        chk("rst_s_ready", s_ready, 1);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_AB_o", AB_o, 8'h00);
        chk("rst_DB_o", DB_o, 8'h00);
        chk("rst_DB_oe", DB_oe, 0);
        chk("rst_rd_n", rd_n, 1);
        chk("rst_wr_n", wr_n, 1);
        chk("rst_level", level, 0);
        chk("rst_busy", busy, 1);
        chk("rst_state", dbg_state, ST_INIT_REQ);

        // INIT write after release with grant tied high
        repeat (3) @(negedge clk);
        exp_q.push_back(wr_t(SCON, 8'h40));
        rst_n = 1'b1;
        wait_drain(2, "init_write");
        repeat (5) @(negedge clk);
        chk("idle_bus_req", bus_req, 0);
        chk("idle_rd_n", rd_n, 1);
        chk("idle_wr_n", wr_n, 1);
        chk("idle_busy", busy, 0);
        chk("idle_state", dbg_state, ST_IDLE);

        // Single byte: SBUF write, SCON poll reading 0x42, TI cleared -> 0x40
        exp_q.push_back(wr_t(SBUF, 8'hA5));
        exp_q.push_back(rd_t(SCON));
        exp_q.push_back(wr_t(SCON, 8'h40));
        push_byte(8'hA5, acc);
        chk("a5_accept", acc, 1);
        wait_drain(300, "single_byte");
        repeat (3) @(negedge clk);
        chk("a5_busy_done", busy, 0);
        chk("a5_level_done", level, 0);

        // Fill past full with the bus withheld
        @(negedge clk);
        bus_gnt = 1'b0;
        n_acc = 0;
        for (int i = 1; i <= 8; i++) begin
            push_byte(8'(i), acc);
            if (acc) n_acc++;
        end
        push_byte(8'h09, acc);
        chk("fill_accepted", n_acc, 8);
        chk("fill_9th_dropped", acc, 0);
        chk("fill_level", level, 8);
        chk("fill_s_ready", s_ready, 0);

        // Grant withheld for 100 cycles in TX_REQ
        repeat (100) @(negedge clk);
        chk("hold_bus_req", bus_req, 1);
        chk("hold_state", dbg_state, ST_TX_REQ);
        chk("hold_level", level, 8);

        // Release the bus: bytes 1..8 in order, each followed by poll and clear
        for (int i = 1; i <= 8; i++) begin
            exp_q.push_back(wr_t(SBUF, 8'(i)));
            exp_q.push_back(rd_t(SCON));
            exp_q.push_back(wr_t(SCON, 8'h40));
        end
        bus_gnt = 1'b1;
        wait_drain(2500, "burst_drain");
        repeat (100) @(negedge clk);
        chk("burst_level", level, 0);
        chk("burst_busy", busy, 0);

        // RI-only interrupt: first poll reads 0x41 (no write), re-poll reads 0x43
        ri_mode = 1'b1;
        base = rd_cycles.size();
        exp_q.push_back(wr_t(SBUF, 8'h3C));
        exp_q.push_back(rd_t(SCON));
        exp_q.push_back(rd_t(SCON));
        exp_q.push_back(wr_t(SCON, 8'h41));
        push_byte(8'h3C, acc);
        wait_drain(300, "ri_only");
        gap = 0;
        if (rd_cycles.size() >= base + 2) gap = rd_cycles[base+1] - rd_cycles[base];
        n_checks++;
        if (gap < POLL_GAP) begin
            n_fail++;
            $display("FAIL ri_repoll_gap: got %0d cycles, required at least %0d", gap, POLL_GAP);
        end
        repeat (50) @(negedge clk);
        chk("ri_busy_done", busy, 0);
        ri_mode = 1'b0;

        // Reset in the middle of TX_WR
        bus_gnt = 1'b0;
        push_byte(8'h77, acc);
        push_byte(8'h78, acc);
        repeat (3) @(negedge clk);
        chk("mid_state_req", dbg_state, ST_TX_REQ);
        bus_gnt = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_in_tx_wr", dbg_state, ST_TX_WR);
        chk("mid_wr_low", wr_n, 0);
        chk("mid_level", level, 2);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_wr_n", wr_n, 1);
        chk("mid_rst_DB_oe", DB_oe, 0);
        chk("mid_rst_bus_req", bus_req, 0);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_s_ready", s_ready, 1);
        chk("mid_rst_state", dbg_state, ST_INIT_REQ);
        @(negedge clk);
        exp_q.push_back(wr_t(SCON, 8'h40));
        rst_n = 1'b1;
        wait_drain(2, "reinit_write");
        repeat (20) @(negedge clk);
        chk("reinit_busy", busy, 0);
        chk("reinit_level", level, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
